// File: rtl/heartbeat_top.sv
// Heartbeat LED driver: a "lub-dub" double pulse per beat, each pulse ramping
// its PWM duty up and back down over a triangular envelope.
module heartbeat_top #(
   parameter int CLK_HZ    = 16_000_000,
   parameter int TICK_DIV  = 16000,
   parameter int BEAT_MS   = 1000,
   parameter int PULSE_MS  = 100,
   parameter int GAP_MS    = 200,
   parameter int PWM_BITS  = 8,
   parameter int DUTY_STEP = 5
) (
   input  logic clk,
   input  logic in_rst,
   output logic LED
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_W  = $clog2(BEAT_MS);

   localparam logic [31:0] P_PULSE = 32'(PULSE_MS);
   localparam logic [31:0] P_GAP   = 32'(GAP_MS);
   localparam logic [31:0] P_HALF  = 32'(PULSE_MS / 2);
   localparam logic [31:0] P_STEP  = 32'(DUTY_STEP);
   localparam logic [63:0] P_DUTY_MAX = (64'd1 << PWM_BITS) - 64'd1;
   localparam logic [PWM_BITS-1:0] DUTY_SAT = '1;

   // An illegal parameter set keeps the LED dark instead of producing garbage.
   localparam bit PARAMS_OK = (CLK_HZ > 0) && (TICK_DIV >= 1) && (PULSE_MS >= 2) &&
                              (GAP_MS >= PULSE_MS) && (GAP_MS + PULSE_MS <= BEAT_MS);

   logic [1:0]          sync_reg;
   logic                rst_n_s;
   logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
   logic [MS_W-1:0]     ms_cnt_reg, ms_cnt_next;
   logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
   logic                led_reg, led_next;
   logic                tick;
   logic                in_a, in_b;
   logic [31:0]         ms_ext, offset, env;
   logic [63:0]         prod;
   logic [PWM_BITS-1:0] duty;

   // Asynchronous assertion, release only after two clean clock edges.
   always_ff @(posedge clk or negedge in_rst) begin
      if (!in_rst) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], 1'b1};
      end
   end

   assign rst_n_s = sync_reg[1];
   assign tick    = (div_cnt_reg == DIV_W'(TICK_DIV - 1));

   always_comb begin
      div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
      ms_cnt_next  = ms_cnt_reg;
      if (tick) begin
         ms_cnt_next = (ms_cnt_reg == MS_W'(BEAT_MS - 1)) ? '0 : ms_cnt_reg + MS_W'(1);
      end
      pwm_cnt_next = pwm_cnt_reg + PWM_BITS'(1);
   end

   // Envelope is evaluated in 32/64-bit space so saturation sees the full product.
   always_comb begin
      ms_ext = 32'(ms_cnt_reg);
      in_a   = (ms_ext < P_PULSE);
      in_b   = (ms_ext >= P_GAP) && (ms_ext < P_GAP + P_PULSE);
      offset = in_a ? ms_ext : ms_ext - P_GAP;
      env    = (offset < P_HALF) ? offset : P_PULSE - 32'd1 - offset;
      prod   = {32'd0, env} * {32'd0, P_STEP};
      duty   = (prod > P_DUTY_MAX) ? DUTY_SAT : prod[PWM_BITS-1:0];
      led_next = PARAMS_OK && (in_a || in_b) && (pwm_cnt_reg < duty);
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         div_cnt_reg <= '0;
         ms_cnt_reg  <= '0;
         pwm_cnt_reg <= '0;
         led_reg     <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         ms_cnt_reg  <= ms_cnt_next;
         pwm_cnt_reg <= pwm_cnt_next;
         led_reg     <= led_next;
      end
   end

   assign LED = led_reg;

endmodule

// File: tb/tb_heartbeat_top.sv
// Directed bench for heartbeat_top: small-parameter pattern, duty saturation,
// default-parameter dark first tick and PWM count, and mid-pulse reset.
module tb_heartbeat_top;

   logic tb_clk = 1'b0;
   logic rst_n  = 1'b0;
   logic led_small, led_sat, led_def;

   int checks   = 0;
   int failures = 0;
   int hi_first = 0;
   int hi_second = 0;
   int k;

   always #5 tb_clk = ~tb_clk;

   heartbeat_top #(
      .CLK_HZ(16_000_000), .TICK_DIV(2), .BEAT_MS(20), .PULSE_MS(4),
      .GAP_MS(8), .PWM_BITS(2), .DUTY_STEP(1)
   ) u_small (
      .clk(tb_clk), .in_rst(rst_n), .LED(led_small)
   );

   heartbeat_top #(
      .CLK_HZ(16_000_000), .TICK_DIV(2), .BEAT_MS(20), .PULSE_MS(4),
      .GAP_MS(8), .PWM_BITS(2), .DUTY_STEP(10)
   ) u_sat (
      .clk(tb_clk), .in_rst(rst_n), .LED(led_sat)
   );

   heartbeat_top u_def (
      .clk(tb_clk), .in_rst(rst_n), .LED(led_def)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // LED after rising edge k (counted from release) reflects counter step m = k-3.
   // Small params: beat = 40 clocks, LED high only at m = 4 (ms 2) and m = 20 (ms 10).
   function automatic logic exp_small(input int kk);
      int m;
      if (kk < 3) return 1'b0;
      m = (kk - 3) % 40;
      return (m == 4) || (m == 20);
   endfunction

   // Saturated duty 3 during o = 1,2: high at pwm 0,1,2 within ms 1,2,9,10.
   function automatic logic exp_sat(input int kk);
      int m;
      if (kk < 3) return 1'b0;
      m = (kk - 3) % 40;
      return (m == 2) || (m == 4) || (m == 5) || (m == 18) || (m == 20) || (m == 21);
   endfunction

   task automatic run_pattern(input string phase, input int ncyc);
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge tb_clk);
         #1;
         check_val($sformatf("%s small k=%0d", phase, i), 32'(led_small), 32'(exp_small(i)));
         check_val($sformatf("%s sat k=%0d", phase, i), 32'(led_sat), 32'(exp_sat(i)));
      end
      $display("phase %s: %0d cycles of small/sat pattern compared", phase, ncyc);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge tb_clk);
      #1;
      check_val("reset small", 32'(led_small), 32'd0);
      check_val("reset sat", 32'(led_sat), 32'd0);
      check_val("reset def", 32'(led_def), 32'd0);
      $display("phase reset: LEDs low under reset");

      @(negedge tb_clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 1; i <= 32002; i++) begin
         @(posedge tb_clk);
         #1;
         k = i;
         if (i <= 120) begin
            check_val($sformatf("start small k=%0d", i), 32'(led_small), 32'(exp_small(i)));
            check_val($sformatf("start sat k=%0d", i), 32'(led_sat), 32'(exp_sat(i)));
         end
         if (i <= 3) check_val($sformatf("start def k=%0d", i), 32'(led_def), 32'd0);
         if (i >= 3) begin
            if (i - 3 < 16000) hi_first += int'(led_def);
            else               hi_second += int'(led_def);
         end
      end
      $display("phase start: small/sat pattern and default run compared");
      // ms 0 has zero duty; ms 1 has duty 5 over 62 full PWM periods.
      check_val("def ms0 high count", 32'(hi_first), 32'd0);
      check_val("def ms1 high count", 32'(hi_second), 32'd310);
      $display("phase default: ms0 highs=%0d ms1 highs=%0d", hi_first, hi_second);

      // Advance until counters sit in ms 9 (pulse B) with sat LED high.
      for (int i = 0; i < 40 && (k % 40) != 21; i++) begin
         @(posedge tb_clk);
         #1;
         k++;
      end
      check_val("pre-reset k phase", 32'(k % 40), 32'd21);
      check_val("pre-reset sat high", 32'(led_sat), 32'd1);

      rst_n = 1'b0;
      #1;
      check_val("assert sat", 32'(led_sat), 32'd0);
      check_val("assert small", 32'(led_small), 32'd0);
      check_val("assert def", 32'(led_def), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge tb_clk);
         #1;
         check_val($sformatf("held sat c=%0d", i), 32'(led_sat), 32'd0);
         check_val($sformatf("held small c=%0d", i), 32'(led_small), 32'd0);
      end
      $display("phase midreset: LEDs dropped and held low");

      @(negedge tb_clk);
      rst_n = 1'b1;
      run_pattern("restart", 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
